// File: rtl/instr_encode_loader_if.sv
// Request and instruction-memory write bus of the encode loader.
// The slave modport is the loader side; master is whoever issues requests.
`timescale 1ns/1ps
interface instr_encode_loader_if #(
    parameter int N  = 32,
    parameter int AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_class;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic [N-1:0]  imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [N-1:0]  imem_wdata;

    modport master (
        output in_valid, op_class, rd, rs1, rs2, funct3, funct7b5, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, op_class, rd, rs1, rs2, funct3, funct7b5, imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes RV32I instruction requests into 32-bit words and writes them
// sequentially into an instruction memory, halting on EBREAK or when full.
`timescale 1ns/1ps
module instr_encode_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    instr_encode_loader_if.slave  bus,
    output logic [AW:0]           count,
    output logic                  done,
    output logic                  full,
    output logic                  err
);

    localparam logic [3:0] OP_R      = 4'd0;
    localparam logic [3:0] OP_I      = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LUI    = 4'd5;
    localparam logic [3:0] OP_AUIPC  = 4'd6;
    localparam logic [3:0] OP_JAL    = 4'd7;
    localparam logic [3:0] OP_JALR   = 4'd8;
    localparam logic [3:0] OP_FENCE  = 4'd9;
    localparam logic [3:0] OP_ECALL  = 4'd10;
    localparam logic [3:0] OP_EBREAK = 4'd11;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ENC,
        WR,
        HALT,
        FULL
    } state_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic         funct7b5;
        logic [N-1:0] imm;
    } req_t;

    state_t        state_q, state_d;
    req_t          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   count_q, count_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          err_q, err_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          fits12;
    logic          fits13;
    logic          fits21;

    // Range checks: the immediate must equal the sign extension of its low bits.
    assign fits12 = (req_q.imm[N-1:11] == {(N - 11){req_q.imm[11]}});
    assign fits13 = (req_q.imm[N-1:12] == {(N - 12){req_q.imm[12]}});
    assign fits21 = (req_q.imm[N-1:20] == {(N - 20){req_q.imm[20]}});

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (req_q.op)
            OP_R: begin
                enc_word = {1'b0, req_q.funct7b5, 5'b00000, req_q.rs2, req_q.rs1,
                            req_q.funct3, req_q.rd, 7'b0110011};
            end
            OP_I: begin
                enc_legal = fits12;
                if (req_q.funct3 == 3'b001 || req_q.funct3 == 3'b101) begin
                    enc_word = {1'b0, req_q.funct7b5, 5'b00000, req_q.imm[4:0],
                                req_q.rs1, req_q.funct3, req_q.rd, 7'b0010011};
                end else begin
                    enc_word = {req_q.imm[11:0], req_q.rs1, req_q.funct3,
                                req_q.rd, 7'b0010011};
                end
            end
            OP_LOAD: begin
                enc_legal = fits12;
                enc_word  = {req_q.imm[11:0], req_q.rs1, req_q.funct3,
                             req_q.rd, 7'b0000011};
            end
            OP_STORE: begin
                enc_legal = fits12;
                enc_word  = {req_q.imm[11:5], req_q.rs2, req_q.rs1, req_q.funct3,
                             req_q.imm[4:0], 7'b0100011};
            end
            OP_BRANCH: begin
                enc_legal = fits13 && !req_q.imm[0];
                enc_word  = {req_q.imm[12], req_q.imm[10:5], req_q.rs2, req_q.rs1,
                             req_q.funct3, req_q.imm[4:1], req_q.imm[11], 7'b1100011};
            end
            OP_LUI: begin
                enc_legal = (req_q.imm[11:0] == 12'h000);
                enc_word  = {req_q.imm[31:12], req_q.rd, 7'b0110111};
            end
            OP_AUIPC: begin
                enc_legal = (req_q.imm[11:0] == 12'h000);
                enc_word  = {req_q.imm[31:12], req_q.rd, 7'b0010111};
            end
            OP_JAL: begin
                enc_legal = fits21 && !req_q.imm[0];
                enc_word  = {req_q.imm[20], req_q.imm[10:1], req_q.imm[11],
                             req_q.imm[19:12], req_q.rd, 7'b1101111};
            end
            OP_JALR: begin
                enc_legal = fits12;
                enc_word  = {req_q.imm[11:0], req_q.rs1, 3'b000, req_q.rd, 7'b1100111};
            end
            OP_FENCE:  enc_word = 32'h0FF0000F;
            OP_ECALL:  enc_word = 32'h00000073;
            OP_EBREAK: enc_word = 32'h00100073;
            default: begin
                enc_legal = 1'b0;
                enc_word  = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // restart overrides whatever the state logic decided for this cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    req_d.op       = bus.op_class;
                    req_d.rd       = bus.rd;
                    req_d.rs1      = bus.rs1;
                    req_d.rs2      = bus.rs2;
                    req_d.funct3   = bus.funct3;
                    req_d.funct7b5 = bus.funct7b5;
                    req_d.imm      = bus.imm;
                    state_d        = ENC;
                end
            end
            ENC: begin
                wdata_d = N'(enc_word);
                if (enc_legal) begin
                    state_d = WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                count_d = count_q + (AW + 1)'(1);
                if (addr_q != LAST_ADDR) begin
                    addr_d = addr_q + AW'(1);
                end
                if (req_q.op == OP_EBREAK) begin
                    state_d = HALT;
                end else if (count_d == DEPTH_CNT) begin
                    state_d = FULL;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT:    state_d = HALT;
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    assign bus.in_ready   = rst_n && (state_q == IDLE);
    assign bus.imem_we    = (state_q == WR) && !restart;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign done           = (state_q == HALT);
    assign full           = (state_q == FULL);
    assign err            = err_q;

endmodule
